// File: rtl/rom_arbiter.sv
// Two-requester arbiter in front of a pipelined ROM. Requester 0 is the
// display fetch, requester 1 the host/debug port. Grants are combinational;
// the ROM port is registered and read data returns in grant order.
module rom_arbiter #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 8,
    parameter int ROM_LAT   = 1,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] ROM_addr,
    output logic              ROM_re,
    output logic              ROM_ce,
    input  logic [DATA_W-1:0] ROM_data
);

    localparam logic [3:0] BMAX = 4'(MAX_BURST);

    typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

    state_t      state, state_nxt;
    logic [3:0]  burst_cnt, burst_nxt;
    logic        last_served;
    logic        own, mine, other;
    logic        gnt_any, gnt_id;
    logic        rom_en;
    logic [ADDR_W-1:0] rom_addr_q;

    // One valid/tag entry per in-flight read; stage k is live k+1 cycles
    // after the grant, so stage ROM_LAT lines up with valid ROM_data.
    logic [ROM_LAT:0] vld_pipe;
    logic [ROM_LAT:0] tag_pipe;

    assign own   = (state == OWN1);
    assign mine  = own ? req1 : req0;
    assign other = own ? req0 : req1;

    assign gnt_any = gnt0 | gnt1;
    assign gnt_id  = gnt1;

    // Grant decision and next-state; flush/reset suppress every grant.
    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        state_nxt = state;
        burst_nxt = burst_cnt;
        if (!reset && !flush) begin
            case (state)
                IDLE: begin
                    if (req0 && (!req1 || last_served)) begin
                        gnt0      = 1'b1;
                        state_nxt = OWN0;
                        burst_nxt = 4'd1;
                    end else if (req1) begin
                        gnt1      = 1'b1;
                        state_nxt = OWN1;
                        burst_nxt = 4'd1;
                    end
                end
                OWN0, OWN1: begin
                    if (mine && (burst_cnt < BMAX || !other)) begin
                        // Owner keeps the port; count saturates at the cap.
                        if (own) gnt1 = 1'b1;
                        else     gnt0 = 1'b1;
                        if (burst_cnt < BMAX) burst_nxt = burst_cnt + 4'd1;
                    end else if (other) begin
                        // Burst cap hit or owner dropped: hand over this cycle.
                        if (own) begin
                            gnt0      = 1'b1;
                            state_nxt = OWN0;
                        end else begin
                            gnt1      = 1'b1;
                            state_nxt = OWN1;
                        end
                        burst_nxt = 4'd1;
                    end else begin
                        state_nxt = IDLE;
                        burst_nxt = 4'd0;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    burst_nxt = 4'd0;
                end
            endcase
        end
    end

    // Arbitration state; flush returns to IDLE but keeps fairness history.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            burst_cnt   <= 4'd0;
            last_served <= 1'b1;
        end else begin
            if (flush) begin
                state     <= IDLE;
                burst_cnt <= 4'd0;
            end else begin
                state     <= state_nxt;
                burst_cnt <= burst_nxt;
            end
            if (gnt_any) last_served <= gnt_id;
        end
    end

    // Registered ROM port: strobe for exactly one cycle per transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            rom_en     <= 1'b0;
            rom_addr_q <= '0;
        end else begin
            rom_en <= gnt_any;
            if (gnt_any) rom_addr_q <= gnt_id ? addr1 : addr0;
        end
    end

    assign ROM_re   = rom_en;
    assign ROM_ce   = rom_en;
    assign ROM_addr = rom_addr_q;

    // In-flight valid shift; flush and reset kill everything in flight.
    always_ff @(posedge clk) begin
        if (reset || flush) vld_pipe <= '0;
        else                vld_pipe <= {vld_pipe[ROM_LAT-1:0], gnt_any};
    end

    // Requester tag rides alongside the valid bit.
    always_ff @(posedge clk) begin
        if (reset) tag_pipe <= '0;
        else       tag_pipe <= {tag_pipe[ROM_LAT-1:0], gnt_id};
    end

    // Return stage: capture ROM data into the tagged requester only.
    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= !flush && vld_pipe[ROM_LAT] && !tag_pipe[ROM_LAT];
            rvalid1 <= !flush && vld_pipe[ROM_LAT] &&  tag_pipe[ROM_LAT];
            if (!flush && vld_pipe[ROM_LAT]) begin
                if (tag_pipe[ROM_LAT]) rdata1 <= ROM_data;
                else                   rdata0 <= ROM_data;
            end
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: two instances (ROM_LAT 1 and 3) share stimulus and
// are compared each cycle against a transaction-level model of the rules.
module tb_rom_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, flush, req0, req1;
    logic [3:0] addr0, addr1;

    logic       gnt0_a, gnt1_a, rvalid0_a, rvalid1_a, ROM_re_a, ROM_ce_a;
    logic [7:0] rdata0_a, rdata1_a, data_a;
    logic [3:0] ROM_addr_a;
    logic       gnt0_b, gnt1_b, rvalid0_b, rvalid1_b, ROM_re_b, ROM_ce_b;
    logic [7:0] rdata0_b, rdata1_b, data_b;
    logic [3:0] ROM_addr_b;

    rom_arbiter #(.ADDR_W(4), .DATA_W(8), .ROM_LAT(1), .MAX_BURST(4)) dut_a (
        .clk(clk), .reset(reset), .flush(flush), .req0(req0), .req1(req1),
        .addr0(addr0), .addr1(addr1), .gnt0(gnt0_a), .gnt1(gnt1_a),
        .rvalid0(rvalid0_a), .rvalid1(rvalid1_a), .rdata0(rdata0_a), .rdata1(rdata1_a),
        .ROM_addr(ROM_addr_a), .ROM_re(ROM_re_a), .ROM_ce(ROM_ce_a), .ROM_data(data_a));

    rom_arbiter #(.ADDR_W(4), .DATA_W(8), .ROM_LAT(3), .MAX_BURST(4)) dut_b (
        .clk(clk), .reset(reset), .flush(flush), .req0(req0), .req1(req1),
        .addr0(addr0), .addr1(addr1), .gnt0(gnt0_b), .gnt1(gnt1_b),
        .rvalid0(rvalid0_b), .rvalid1(rvalid1_b), .rdata0(rdata0_b), .rdata1(rdata1_b),
        .ROM_addr(ROM_addr_b), .ROM_re(ROM_re_b), .ROM_ce(ROM_ce_b), .ROM_data(data_b));

    // ROM contents and fixed-latency ROM behaviour for each instance
    logic [7:0] rom [16];
    logic [7:0] pa0, pb0, pb1, pb2;
    always @(posedge clk) begin
        pa0 <= rom[ROM_addr_a];
        pb0 <= rom[ROM_addr_b];
        pb1 <= pb0;
        pb2 <= pb1;
    end
    assign data_a = pa0;
    assign data_b = pb2;

    logic [25:0] obs_a, obs_b, exp_a, exp_b;
    assign obs_a = {gnt0_a, gnt1_a, ROM_re_a, ROM_ce_a, ROM_addr_a, rvalid0_a, rvalid1_a, rdata0_a, rdata1_a};
    assign obs_b = {gnt0_b, gnt1_b, ROM_re_b, ROM_ce_b, ROM_addr_b, rvalid0_b, rvalid1_b, rdata0_b, rdata1_b};

    // ---------------- reference model ----------------
    localparam int MAXB = 4;
    typedef struct {int who; logic [3:0] a; int due;} rd_t;
    rd_t qa[$], qb[$];
    int  cyc_n = 0, owner = -1, run = 0, last = 1, g = -1;
    logic       m_re = 1'b0;
    logic [3:0] m_addr = 4'd0;
    logic [7:0] hold_a [2] = '{8'h0, 8'h0};
    logic [7:0] hold_b [2] = '{8'h0, 8'h0};
    int n_chk = 0, n_err = 0;

    // Expected outputs for the current cycle given current inputs.
    task automatic eval();
        logic [1:0] rv;
        logic [7:0] rd0, rd1;
        logic mine, oth;
        g = -1;
        if (!reset && !flush) begin
            if (owner < 0) begin
                if (req0 && req1) g = (last == 1) ? 0 : 1;
                else if (req0)    g = 0;
                else if (req1)    g = 1;
            end else begin
                mine = (owner == 1) ? req1 : req0;
                oth  = (owner == 1) ? req0 : req1;
                if (mine && (run < MAXB || !oth)) g = owner;
                else if (oth)                     g = 1 - owner;
            end
        end
        rv = 2'b00; rd0 = hold_a[0]; rd1 = hold_a[1];
        if (qa.size() > 0 && qa[0].due == cyc_n) begin
            rv[qa[0].who] = 1'b1;
            if (qa[0].who == 0) rd0 = rom[qa[0].a]; else rd1 = rom[qa[0].a];
        end
        exp_a = {g == 0, g == 1, m_re, m_re, m_addr, rv[0], rv[1], rd0, rd1};
        rv = 2'b00; rd0 = hold_b[0]; rd1 = hold_b[1];
        if (qb.size() > 0 && qb[0].due == cyc_n) begin
            rv[qb[0].who] = 1'b1;
            if (qb[0].who == 0) rd0 = rom[qb[0].a]; else rd1 = rom[qb[0].a];
        end
        exp_b = {g == 0, g == 1, m_re, m_re, m_addr, rv[0], rv[1], rd0, rd1};
        #1;
    endtask

    // Advance the model across the clock edge.
    task automatic commit();
        rd_t e;
        if (qa.size() > 0 && qa[0].due == cyc_n) begin hold_a[qa[0].who] = rom[qa[0].a]; void'(qa.pop_front()); end
        if (qb.size() > 0 && qb[0].due == cyc_n) begin hold_b[qb[0].who] = rom[qb[0].a]; void'(qb.pop_front()); end
        if (reset) begin
            owner = -1; run = 0; last = 1; qa.delete(); qb.delete();
            m_re = 1'b0; m_addr = 4'd0;
            hold_a = '{8'h0, 8'h0}; hold_b = '{8'h0, 8'h0};
        end else if (flush) begin
            owner = -1; run = 0; qa.delete(); qb.delete(); m_re = 1'b0;
        end else if (g >= 0) begin
            last = g;
            if (g == owner) run = (run < MAXB) ? run + 1 : MAXB;
            else begin owner = g; run = 1; end
            m_re = 1'b1;
            m_addr = (g == 1) ? addr1 : addr0;
            e.who = g; e.a = m_addr;
            e.due = cyc_n + 3; qa.push_back(e);
            e.due = cyc_n + 5; qb.push_back(e);
        end else begin
            m_re = 1'b0; owner = -1; run = 0;
        end
        cyc_n++;
    endtask

    task automatic adv();
        @(posedge clk);
        commit();
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; req0 = 1'b0; req1 = 1'b0; addr0 = 4'd0; addr1 = 4'd0;
        eval(); adv();
        for (int k = 0; k < 2; k++) begin
            req0 = 1'b1; req1 = (k == 1);
            eval();
            n_chk++; if (obs_a !== exp_a) begin n_err++; $display("FAIL reset_a cyc=%0d got=%h exp=%h", cyc_n, obs_a, exp_a); end
            n_chk++; if (obs_b !== exp_b) begin n_err++; $display("FAIL reset_b cyc=%0d got=%h exp=%h", cyc_n, obs_b, exp_b); end
            n_chk++; if ({gnt0_a, gnt1_a, ROM_re_a, ROM_addr_a, rvalid0_a, rdata0_a} !== 16'h0)
                begin n_err++; $display("FAIL reset_vals got=%b%b%b %h %b %h exp=all zero", gnt0_a, gnt1_a, ROM_re_a, ROM_addr_a, rvalid0_a, rdata0_a); end
            adv();
        end
        reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_single();
        for (int k = 0; k < 6; k++) begin
            req0 = (k == 0); addr0 = 4'd3;
            eval();
            n_chk++; if (obs_a !== exp_a) begin n_err++; $display("FAIL single_a cyc=%0d got=%h exp=%h", cyc_n, obs_a, exp_a); end
            n_chk++; if (obs_b !== exp_b) begin n_err++; $display("FAIL single_b cyc=%0d got=%h exp=%h", cyc_n, obs_b, exp_b); end
            if (k == 1) begin
                n_chk++; if ({ROM_re_a, ROM_ce_a, ROM_addr_a} !== 6'b11_0011)
                    begin n_err++; $display("FAIL single_rom got=%b%b %h exp=11 3", ROM_re_a, ROM_ce_a, ROM_addr_a); end
            end
            if (k == 3) begin
                n_chk++; if ({rvalid0_a, rdata0_a} !== 9'h1A5)
                    begin n_err++; $display("FAIL single_data got=%b %h exp=1 a5", rvalid0_a, rdata0_a); end
            end
            adv();
        end
    endtask

    task automatic test_fairness();
        int exp_seq [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
        reset = 1'b1; eval(); adv(); reset = 1'b0;
        for (int k = 0; k < 16; k++) begin
            req0 = (k < 10); req1 = (k < 10); addr0 = 4'(k); addr1 = 4'(15 - k);
            eval();
            n_chk++; if (obs_a !== exp_a) begin n_err++; $display("FAIL fair_a cyc=%0d got=%h exp=%h", cyc_n, obs_a, exp_a); end
            n_chk++; if (obs_b !== exp_b) begin n_err++; $display("FAIL fair_b cyc=%0d got=%h exp=%h", cyc_n, obs_b, exp_b); end
            if (k < 10) begin
                n_chk++; if ({gnt0_a, gnt1_a} !== {exp_seq[k] == 0, exp_seq[k] == 1})
                    begin n_err++; $display("FAIL fair_order k=%0d got=%b%b exp_owner=%0d", k, gnt0_a, gnt1_a, exp_seq[k]); end
            end
            if (k >= 1 && k <= 10) begin
                n_chk++; if (ROM_re_a !== 1'b1) begin n_err++; $display("FAIL fair_rom_re k=%0d got=%b exp=1", k, ROM_re_a); end
            end
            adv();
        end
    endtask

    task automatic test_handover();
        int exp_g1 [6] = '{1, 1, 1, 1, 0, 0};
        reset = 1'b1; eval(); adv(); reset = 1'b0;
        for (int k = 0; k < 14; k++) begin
            req0 = (k == 0 || k == 1 || (k >= 3 && k < 8));
            req1 = (k >= 1 && k < 8);
            addr0 = 4'd2; addr1 = 4'd7;
            eval();
            n_chk++; if (obs_a !== exp_a) begin n_err++; $display("FAIL hand_a cyc=%0d got=%h exp=%h", cyc_n, obs_a, exp_a); end
            n_chk++; if (obs_b !== exp_b) begin n_err++; $display("FAIL hand_b cyc=%0d got=%h exp=%h", cyc_n, obs_b, exp_b); end
            if (k >= 2 && k < 8) begin
                n_chk++; if (gnt1_a !== 1'(exp_g1[k-2]) || gnt0_a !== 1'(1 - exp_g1[k-2]))
                    begin n_err++; $display("FAIL hand_gnt k=%0d got=%b%b exp_gnt1=%0d", k, gnt0_a, gnt1_a, exp_g1[k-2]); end
            end
            if (k >= 1 && k <= 8) begin
                n_chk++; if (ROM_re_a !== 1'b1) begin n_err++; $display("FAIL hand_rom_re k=%0d got=%b exp=1", k, ROM_re_a); end
            end
            adv();
        end
    endtask

    task automatic test_flush();
        int cnt_a = 0, cnt_b = 0;
        reset = 1'b1; eval(); adv(); reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            req0 = (k < 3); addr0 = 4'(k + 4);
            flush = (k == 2);
            req1 = (k == 4); addr1 = 4'd12;
            eval();
            n_chk++; if (obs_a !== exp_a) begin n_err++; $display("FAIL flush_a cyc=%0d got=%h exp=%h", cyc_n, obs_a, exp_a); end
            n_chk++; if (obs_b !== exp_b) begin n_err++; $display("FAIL flush_b cyc=%0d got=%h exp=%h", cyc_n, obs_b, exp_b); end
            if (k == 2) begin
                n_chk++; if ({gnt0_a, gnt1_a} !== 2'b00) begin n_err++; $display("FAIL flush_gnt got=%b%b exp=00", gnt0_a, gnt1_a); end
            end
            if (k == 3) begin
                n_chk++; if (ROM_re_a !== 1'b0) begin n_err++; $display("FAIL flush_rom_re got=%b exp=0", ROM_re_a); end
            end
            if (k == 7) begin
                n_chk++; if ({rvalid1_a, rdata1_a} !== {1'b1, rom[12]})
                    begin n_err++; $display("FAIL flush_new got=%b %h exp=1 %h", rvalid1_a, rdata1_a, rom[12]); end
            end
            if (k >= 3) begin
                cnt_a += int'(rvalid0_a) + int'(rvalid1_a);
                cnt_b += int'(rvalid0_b) + int'(rvalid1_b);
            end
            adv();
        end
        flush = 1'b0;
        n_chk++; if (cnt_a != 1) begin n_err++; $display("FAIL flush_cnt_a got=%0d exp=1", cnt_a); end
        n_chk++; if (cnt_b != 1) begin n_err++; $display("FAIL flush_cnt_b got=%0d exp=1", cnt_b); end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 12; k++) begin
            reset = (k == 3);
            req0 = (k <= 4); req1 = (k == 4);
            addr0 = 4'(k + 1); addr1 = 4'd14;
            eval();
            n_chk++; if (obs_a !== exp_a) begin n_err++; $display("FAIL rmid_a cyc=%0d got=%h exp=%h", cyc_n, obs_a, exp_a); end
            n_chk++; if (obs_b !== exp_b) begin n_err++; $display("FAIL rmid_b cyc=%0d got=%h exp=%h", cyc_n, obs_b, exp_b); end
            if (k == 4) begin
                n_chk++; if ({gnt0_a, gnt1_a, ROM_re_a, ROM_addr_a, rvalid0_a, rvalid1_a, rdata0_a, rdata1_a} !== {2'b10, 23'h0})
                    begin n_err++; $display("FAIL rmid_post got=%b%b %b %h %b%b %h %h exp=10 all else zero",
                        gnt0_a, gnt1_a, ROM_re_a, ROM_addr_a, rvalid0_a, rvalid1_a, rdata0_a, rdata1_a); end
            end
            if (k == 5 || k == 6) begin
                n_chk++; if ({rvalid0_a, rvalid1_a, rvalid0_b, rvalid1_b} !== 4'b0)
                    begin n_err++; $display("FAIL rmid_stale k=%0d got=%b%b%b%b exp=0000", k, rvalid0_a, rvalid1_a, rvalid0_b, rvalid1_b); end
            end
            adv();
        end
        reset = 1'b0;
    endtask

    task automatic test_sweep();
        int j;
        reset = 1'b1; eval(); adv(); reset = 1'b0;
        for (int k = 0; k < 24; k++) begin
            req0 = (k < 16) && (k % 2 == 0);
            req1 = (k < 16) && (k % 2 == 1);
            addr0 = 4'(k); addr1 = 4'(k);
            eval();
            n_chk++; if (obs_a !== exp_a) begin n_err++; $display("FAIL sweep_a cyc=%0d got=%h exp=%h", cyc_n, obs_a, exp_a); end
            n_chk++; if (obs_b !== exp_b) begin n_err++; $display("FAIL sweep_b cyc=%0d got=%h exp=%h", cyc_n, obs_b, exp_b); end
            j = k - 5;
            if (j >= 0 && j < 16) begin
                n_chk++;
                if ((j % 2 == 1 ? {rvalid1_b, rvalid0_b, rdata1_b} : {rvalid0_b, rvalid1_b, rdata0_b}) !== {2'b10, rom[j]})
                    begin n_err++; $display("FAIL sweep_lat3 j=%0d got=%b%b %h %h exp_tag=%0d data=%h",
                        j, rvalid0_b, rvalid1_b, rdata0_b, rdata1_b, j % 2, rom[j]); end
            end
            adv();
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            if (!req0 || g == 0) addr0 = 4'($urandom);
            if (!req1 || g == 1) addr1 = 4'($urandom);
            req0  = ($urandom_range(0, 3) != 0);
            req1  = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 24) == 0);
            reset = ($urandom_range(0, 59) == 0);
            eval();
            n_chk++; if (obs_a !== exp_a) begin n_err++; $display("FAIL rand_a cyc=%0d got=%h exp=%h", cyc_n, obs_a, exp_a); end
            n_chk++; if (obs_b !== exp_b) begin n_err++; $display("FAIL rand_b cyc=%0d got=%h exp=%h", cyc_n, obs_b, exp_b); end
            adv();
        end
        reset = 1'b0; flush = 1'b0; req0 = 1'b0; req1 = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
        rom[3] = 8'hA5;
        test_reset();
        test_single();
        test_fairness();
        test_handover();
        test_flush();
        test_reset_mid();
        test_sweep();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
